// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ID/EX control-bit indices, payload field offsets,
// pack/unpack helpers and the skid-buffer occupancy states.
package pipe_pkg;

    localparam int REGWRITE  = 0;
    localparam int MEMTOREG  = 1;
    localparam int SHIFT     = 2;
    localparam int MF        = 3;
    localparam int BRANCH    = 4;
    localparam int MEMWRITE  = 5;
    localparam int MEMREAD   = 6;
    localparam int JUMP      = 7;
    localparam int ALUSRC    = 8;
    localparam int HIORLO    = 9;
    localparam int REGDST    = 10;
    localparam int ALUOP_LSB = 11;
    localparam int ALUOP_W   = 2;
    localparam int IDEX_CTRL_W = 13;

    localparam int WORD_W      = 32;
    localparam int IMM_W       = 16;
    localparam int REG_W       = 5;
    localparam int PC4_LSB     = 0;
    localparam int RD1_LSB     = 32;
    localparam int RD2_LSB     = 64;
    localparam int IMM_LSB     = 96;
    localparam int RT_LSB      = 112;
    localparam int RD_LSB      = 117;
    localparam int SHAMT_LSB   = 122;
    localparam int IDEX_DATA_W = 128;

    typedef struct packed {
        logic [ALUOP_W-1:0] aluop;
        logic regdst;
        logic hiorlo;
        logic alusrc;
        logic jump;
        logic memread;
        logic memwrite;
        logic branch;
        logic mf;
        logic shift;
        logic memtoreg;
        logic regwrite;
    } idex_ctrl_t;

    typedef struct packed {
        logic [REG_W-1:0]  shamt;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rt;
        logic [IMM_W-1:0]  imm;
        logic [WORD_W-1:0] rd2;
        logic [WORD_W-1:0] rd1;
        logic [WORD_W-1:0] pc4;
    } idex_data_t;

    // Occupancy of the skid variant; the encoding doubles as the entry count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

    function automatic logic [IDEX_CTRL_W-1:0] pack_idex_ctrl(input idex_ctrl_t c);
        logic [IDEX_CTRL_W-1:0] w;
        w = '0;
        w[REGWRITE] = c.regwrite;
        w[MEMTOREG] = c.memtoreg;
        w[SHIFT]    = c.shift;
        w[MF]       = c.mf;
        w[BRANCH]   = c.branch;
        w[MEMWRITE] = c.memwrite;
        w[MEMREAD]  = c.memread;
        w[JUMP]     = c.jump;
        w[ALUSRC]   = c.alusrc;
        w[HIORLO]   = c.hiorlo;
        w[REGDST]   = c.regdst;
        w[ALUOP_LSB +: ALUOP_W] = c.aluop;
        return w;
    endfunction

    function automatic idex_ctrl_t unpack_idex_ctrl(input logic [IDEX_CTRL_W-1:0] w);
        idex_ctrl_t c;
        c.regwrite = w[REGWRITE];
        c.memtoreg = w[MEMTOREG];
        c.shift    = w[SHIFT];
        c.mf       = w[MF];
        c.branch   = w[BRANCH];
        c.memwrite = w[MEMWRITE];
        c.memread  = w[MEMREAD];
        c.jump     = w[JUMP];
        c.alusrc   = w[ALUSRC];
        c.hiorlo   = w[HIORLO];
        c.regdst   = w[REGDST];
        c.aluop    = w[ALUOP_LSB +: ALUOP_W];
        return c;
    endfunction

    function automatic logic [IDEX_DATA_W-1:0] pack_idex_data(input idex_data_t d);
        logic [IDEX_DATA_W-1:0] w;
        w = '0;
        w[PC4_LSB   +: WORD_W] = d.pc4;
        w[RD1_LSB   +: WORD_W] = d.rd1;
        w[RD2_LSB   +: WORD_W] = d.rd2;
        w[IMM_LSB   +: IMM_W]  = d.imm;
        w[RT_LSB    +: REG_W]  = d.rt;
        w[RD_LSB    +: REG_W]  = d.rd;
        w[SHAMT_LSB +: REG_W]  = d.shamt;
        return w;
    endfunction

    function automatic idex_data_t unpack_idex_data(input logic [IDEX_DATA_W-1:0] w);
        idex_data_t d;
        d.pc4   = w[PC4_LSB   +: WORD_W];
        d.rd1   = w[RD1_LSB   +: WORD_W];
        d.rd2   = w[RD2_LSB   +: WORD_W];
        d.imm   = w[IMM_LSB   +: IMM_W];
        d.rt    = w[RT_LSB    +: REG_W];
        d.rd    = w[RD_LSB    +: REG_W];
        d.shamt = w[SHAMT_LSB +: REG_W];
        return d;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle of a pipeline stage register: upstream side, downstream side,
// flush and occupancy. master drives the stage inputs, slave is the stage itself.
interface pipe_stage_reg_if #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 128
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        count;

    modport master (
        output in_valid, in_ctrl, in_data, flush, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data, count
    );

    modport slave (
        input  in_valid, in_ctrl, in_data, flush, out_ready,
        output in_ready, out_valid, out_ctrl, out_data, count
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready back-pressure, flush-to-bubble
// and an optional 2-entry skid buffer that registers the upstream ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 128,
    parameter int SKID   = 1
) (
    input logic            clk,
    input logic            rst,
    pipe_stage_reg_if.slave bus
);

    logic              out_valid_w;
    logic              in_ready_w;
    logic [CTRL_W-1:0] main_ctrl_w;
    logic [DATA_W-1:0] main_data_w;
    logic [1:0]        count_w;

    generate
        if (SKID != 0) begin : g_skid
            skid_state_t       state_reg;
            logic              in_ready_reg;
            logic              out_valid_reg;
            logic [CTRL_W-1:0] main_ctrl_reg;
            logic [DATA_W-1:0] main_data_reg;
            logic [CTRL_W-1:0] skid_ctrl_reg;
            logic [DATA_W-1:0] skid_data_reg;
            logic              xfer_in;
            logic              xfer_out;

            assign xfer_in  = bus.in_valid && in_ready_reg;
            assign xfer_out = out_valid_reg && bus.out_ready;

            // in_ready_reg tracks (next occupancy < 2) so upstream never sees out_ready.
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg     <= ST_EMPTY;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    main_ctrl_reg <= '0;
                    main_data_reg <= '0;
                    skid_ctrl_reg <= '0;
                    skid_data_reg <= '0;
                end else if (bus.flush) begin
                    state_reg     <= ST_EMPTY;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end else begin
                    case (state_reg)
                        ST_EMPTY: begin
                            if (xfer_in) begin
                                main_ctrl_reg <= bus.in_ctrl;
                                main_data_reg <= bus.in_data;
                                out_valid_reg <= 1'b1;
                                state_reg     <= ST_ONE;
                            end
                        end
                        ST_ONE: begin
                            if (xfer_in && xfer_out) begin
                                main_ctrl_reg <= bus.in_ctrl;
                                main_data_reg <= bus.in_data;
                            end else if (xfer_in) begin
                                skid_ctrl_reg <= bus.in_ctrl;
                                skid_data_reg <= bus.in_data;
                                in_ready_reg  <= 1'b0;
                                state_reg     <= ST_FULL;
                            end else if (xfer_out) begin
                                out_valid_reg <= 1'b0;
                                state_reg     <= ST_EMPTY;
                            end
                        end
                        ST_FULL: begin
                            if (xfer_out) begin
                                main_ctrl_reg <= skid_ctrl_reg;
                                main_data_reg <= skid_data_reg;
                                in_ready_reg  <= 1'b1;
                                state_reg     <= ST_ONE;
                            end
                        end
                        default: begin
                            state_reg     <= ST_EMPTY;
                            in_ready_reg  <= 1'b1;
                            out_valid_reg <= 1'b0;
                        end
                    endcase
                end
            end

            assign in_ready_w  = in_ready_reg;
            assign out_valid_w = out_valid_reg;
            assign main_ctrl_w = main_ctrl_reg;
            assign main_data_w = main_data_reg;
            assign count_w     = state_reg;
        end else begin : g_flow
            logic              out_valid_reg;
            logic [CTRL_W-1:0] main_ctrl_reg;
            logic [DATA_W-1:0] main_data_reg;
            logic              xfer_in;
            logic              xfer_out;

            // Ready ripples straight back from downstream in this variant.
            assign in_ready_w = !out_valid_reg || bus.out_ready;
            assign xfer_in    = bus.in_valid && in_ready_w;
            assign xfer_out   = out_valid_reg && bus.out_ready;

            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid_reg <= 1'b0;
                    main_ctrl_reg <= '0;
                    main_data_reg <= '0;
                end else if (bus.flush) begin
                    out_valid_reg <= 1'b0;
                end else if (xfer_in) begin
                    main_ctrl_reg <= bus.in_ctrl;
                    main_data_reg <= bus.in_data;
                    out_valid_reg <= 1'b1;
                end else if (xfer_out) begin
                    out_valid_reg <= 1'b0;
                end
            end

            assign out_valid_w = out_valid_reg;
            assign main_ctrl_w = main_ctrl_reg;
            assign main_data_w = main_data_reg;
            assign count_w     = {1'b0, out_valid_reg};
        end
    endgenerate

    // Bubbles reach downstream as an all-zero control word; payload is left as is.
    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_ctrl  = out_valid_w ? main_ctrl_w : '0;
    assign bus.out_data  = main_data_w;
    assign bus.count     = count_w;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a flow-through (SKID=0) and a skid (SKID=1) stage with the same stimulus
// and checks both against a queue-based reference model.
module tb_pipe_stage_reg;

    localparam int CW = 16;
    localparam int DW = 128;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_ready;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit mon_en    = 1'b0;

    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) if0 ();
    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) if1 ();

    assign if0.in_valid = in_valid;
    assign if0.in_ctrl  = in_ctrl;
    assign if0.in_data  = in_data;
    assign if0.flush    = flush;
    assign if0.out_ready = out_ready;
    assign if1.in_valid = in_valid;
    assign if1.in_ctrl  = in_ctrl;
    assign if1.in_data  = in_data;
    assign if1.flush    = flush;
    assign if1.out_ready = out_ready;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) u_dut_flow (
        .clk(clk), .rst(rst), .bus(if0.slave)
    );
    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) u_dut_skid (
        .clk(clk), .rst(rst), .bus(if1.slave)
    );

    always #5 clk = ~clk;

    logic          s_valid [2];
    logic          s_ready [2];
    logic [1:0]    s_count [2];
    logic [CW-1:0] s_ctrl  [2];
    logic [DW-1:0] s_data  [2];

    assign s_valid[0] = if0.out_valid;
    assign s_ready[0] = if0.in_ready;
    assign s_count[0] = if0.count;
    assign s_ctrl[0]  = if0.out_ctrl;
    assign s_data[0]  = if0.out_data;
    assign s_valid[1] = if1.out_valid;
    assign s_ready[1] = if1.in_ready;
    assign s_count[1] = if1.count;
    assign s_ctrl[1]  = if1.out_ctrl;
    assign s_data[1]  = if1.out_data;

    task automatic chk(input int id, input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL dut%0d %s: got %h expected %h", id, nm, act, exp);
    endtask

    // Reference model: accepted entries in arrival order; capacity 2 (skid) or 1 (flow).
    ent_t          exp_q [2][$];
    logic [DW-1:0] hold  [2];

    always @(negedge clk) begin
        int   sz;
        logic exp_rdy;
        ent_t e;
        if (mon_en) begin
            for (int id = 0; id < 2; id++) begin
                sz = exp_q[id].size();
                exp_rdy = (id == 1) ? (sz < 2) : (sz == 0 || out_ready);
                chk(id, "out_valid", DW'(s_valid[id]), DW'(sz > 0));
                chk(id, "count", DW'(s_count[id]), DW'(sz));
                chk(id, "in_ready", DW'(s_ready[id]), DW'(exp_rdy));
                chk(id, "out_ctrl", DW'(s_ctrl[id]), (sz > 0) ? DW'(exp_q[id][0].ctrl) : '0);
                chk(id, "out_data", s_data[id], (sz > 0) ? exp_q[id][0].data : hold[id]);
                if (rst) begin
                    exp_q[id].delete();
                    hold[id] = '0;
                end else if (flush) begin
                    exp_q[id].delete();
                end else begin
                    if (sz > 0 && out_ready) begin
                        e = exp_q[id].pop_front();
                        $display("dut%0d xfer out ctrl=%h data=%h", id, e.ctrl, e.data);
                    end
                    if (in_valid && exp_rdy) exp_q[id].push_back({in_ctrl, in_data});
                end
                if (exp_q[id].size() > 0) hold[id] = exp_q[id][0].data;
            end
        end
    end

    task automatic cyc(input bit r, input bit v, input logic [CW-1:0] c, input bit ordy, input bit fl);
        rst       = r;
        in_valid  = v;
        in_ctrl   = c;
        in_data   = {$urandom, $urandom, $urandom, $urandom};
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        hold[0] = '0;
        hold[1] = '0;
        @(posedge clk);
        mon_en = 1'b1;
    end

    initial begin
        // Reset held two cycles with a valid offered
        cyc(1, 1, 16'hAAAA, 1, 0);
        cyc(1, 1, 16'hAAAA, 1, 0);
        cyc(0, 0, 16'h0000, 1, 0);

        // Streaming ctrl 1..8
        for (int i = 1; i <= 8; i++) cyc(0, 1, CW'(i), 1, 0);
        cyc(0, 0, 16'h0000, 1, 0);
        cyc(0, 0, 16'h0000, 1, 0);

        // Back-pressure then release
        cyc(0, 1, 16'h0011, 0, 0);
        cyc(0, 1, 16'h0022, 0, 0);
        cyc(0, 1, 16'h0033, 0, 0);
        cyc(0, 1, 16'h0033, 0, 0);
        cyc(0, 1, 16'h0033, 1, 0);
        cyc(0, 1, 16'h0033, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 16'h0000, 1, 0);

        // Flush while full with an incoming entry
        cyc(0, 1, 16'h0101, 0, 0);
        cyc(0, 1, 16'h0202, 0, 0);
        cyc(0, 1, 16'h0044, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 16'h0000, 1, 0);

        // Flow-through ready follows out_ready within the cycle
        cyc(0, 1, 16'h0055, 0, 0);
        in_valid  = 1'b1;
        in_ctrl   = 16'h0066;
        out_ready = 1'b0;
        #1;
        chk(0, "comb_ready_low", DW'(if0.in_ready), DW'(1'b0));
        out_ready = 1'b1;
        #1;
        chk(0, "comb_ready_high", DW'(if0.in_ready), DW'(1'b1));
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cyc(0, 0, 16'h0000, 1, 0);

        // Bubble gating after an all-ones control word
        cyc(0, 1, 16'hFFFF, 1, 0);
        cyc(0, 0, 16'h0000, 1, 0);
        cyc(0, 0, 16'h0000, 1, 0);
        cyc(0, 0, 16'h0000, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, CW'($urandom),
                $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0);
        end
        for (int i = 0; i < 4; i++) cyc(0, 0, 16'h0000, 1, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
